// File: rtl/pll_reconfig_ctrl.sv
// pll_reconfig_ctrl: power-up and reconfiguration sequencer for a PLLVR in
// dynamic-divider mode. The sequence is: hold the PLL in reset, release it,
// wait for lock with a timeout and a bounded number of retries, then qualify
// lock before reporting `locked`.
// Optional feature macro: PLL_RECONFIG_LOCK_MON_EN. When it is defined, a loss
// of lock in RUN re-sequences the PLL with the current codes. When it is
// undefined, a loss of lock goes to FAIL.
module pll_reconfig_ctrl #(
    parameter int         RST_HOLD_CYCLES = 32,
    parameter int         LOCK_TIMEOUT    = 4096,
    parameter int         LOCK_STABLE     = 16,
    parameter int         MAX_RETRY       = 3,
    parameter logic [5:0] INIT_IDSEL      = 6'd0,
    parameter logic [5:0] INIT_FBDSEL     = 6'd0,
    parameter logic [5:0] INIT_ODSEL      = 6'd0
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [5:0] cfg_idsel,
    input  logic [5:0] cfg_fbdsel,
    input  logic [5:0] cfg_odsel,
    output logic       pll_reset,
    output logic [5:0] pll_idsel,
    output logic [5:0] pll_fbdsel,
    output logic [5:0] pll_odsel,
    input  logic       pll_lock,
    output logic       locked,
    output logic       busy,
    output logic       err,
    output logic [1:0] retry_cnt
);

    localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);

    typedef enum logic [2:0] {
        ST_RESET_HOLD,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [SW-1:0]   stable_cnt_q, stable_cnt_d;
    logic [1:0]      retry_q, retry_d;
    logic            err_q, err_d;
    logic [5:0]      idsel_q, idsel_d;
    logic [5:0]      fbdsel_q, fbdsel_d;
    logic [5:0]      odsel_q, odsel_d;
    logic            pll_reset_q, pll_reset_d;
    logic            locked_q, locked_d;
    logic            busy_q, busy_d;
    logic            cfg_ready_q, cfg_ready_d;
    logic            sync1_q, lock_s_q;

    logic            accept;
    logic            hold_done;
    logic            timeout;
    logic            stable_done;

    assign accept      = cfg_valid && cfg_ready_q;
    assign hold_done   = (hold_cnt_q == HW'(RST_HOLD_CYCLES));
    assign timeout     = (to_cnt_q == TW'(LOCK_TIMEOUT));
    assign stable_done = (stable_cnt_q == SW'(LOCK_STABLE));

    // Two-flop synchronizer: pll_lock is asynchronous to clkin.
    always_ff @(posedge clkin) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    // Next-state logic, counters and registered-output precomputation.
    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        err_d    = err_q;
        idsel_d  = idsel_q;
        fbdsel_d = fbdsel_q;
        odsel_d  = odsel_q;

        case (state_q)
            ST_RESET_HOLD: begin
                if (hold_done) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (timeout) begin
                    if (retry_q < 2'(MAX_RETRY)) begin
                        retry_d = retry_q + 2'd1;
                        state_d = ST_RESET_HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FAIL;
                    end
                end else if (lock_s_q) begin
                    state_d = ST_STABLE;
                end
            end
            ST_STABLE: begin
                // The timeout keeps running while lock is being qualified and wins.
                if (timeout) begin
                    if (retry_q < 2'(MAX_RETRY)) begin
                        retry_d = retry_q + 2'd1;
                        state_d = ST_RESET_HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FAIL;
                    end
                end else if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stable_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
`ifdef PLL_RECONFIG_LOCK_MON_EN
                    retry_d = 2'd0;
                    state_d = ST_RESET_HOLD;
`else
                    err_d   = 1'b1;
                    state_d = ST_FAIL;
`endif
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RESET_HOLD;
            end
        endcase

        // An accepted config overrides everything, including lock loss in RUN.
        if (accept) begin
            state_d  = ST_RESET_HOLD;
            retry_d  = 2'd0;
            err_d    = 1'b0;
            idsel_d  = cfg_idsel;
            fbdsel_d = cfg_fbdsel;
            odsel_d  = cfg_odsel;
        end

        // Hold counter restarts from zero on every entry into RESET_HOLD.
        hold_cnt_d = '0;
        if (state_q == ST_RESET_HOLD && state_d == ST_RESET_HOLD) begin
            hold_cnt_d = hold_done ? hold_cnt_q : hold_cnt_q + HW'(1);
        end

        // Timeout counter spans WAIT_LOCK and STABLE without being reset between them.
        to_cnt_d = '0;
        if ((state_q == ST_WAIT_LOCK || state_q == ST_STABLE) &&
            (state_d == ST_WAIT_LOCK || state_d == ST_STABLE)) begin
            to_cnt_d = timeout ? to_cnt_q : to_cnt_q + TW'(1);
        end

        // The cycle that moves WAIT_LOCK to STABLE is itself the first high cycle.
        stable_cnt_d = '0;
        if (state_d == ST_STABLE) begin
            if (state_q == ST_STABLE) begin
                stable_cnt_d = stable_done ? stable_cnt_q : stable_cnt_q + SW'(1);
            end else begin
                stable_cnt_d = SW'(1);
            end
        end

        pll_reset_d = (state_d == ST_RESET_HOLD) || (state_d == ST_FAIL);
        locked_d    = (state_d == ST_RUN);
        busy_d      = (state_d == ST_RESET_HOLD) || (state_d == ST_WAIT_LOCK) ||
                      (state_d == ST_STABLE);
        cfg_ready_d = (state_d == ST_RUN) || (state_d == ST_FAIL);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q      <= ST_RESET_HOLD;
            hold_cnt_q   <= '0;
            to_cnt_q     <= '0;
            stable_cnt_q <= '0;
            retry_q      <= 2'd0;
            err_q        <= 1'b0;
            idsel_q      <= INIT_IDSEL;
            fbdsel_q     <= INIT_FBDSEL;
            odsel_q      <= INIT_ODSEL;
            pll_reset_q  <= 1'b1;
            locked_q     <= 1'b0;
            busy_q       <= 1'b1;
            cfg_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            to_cnt_q     <= to_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            retry_q      <= retry_d;
            err_q        <= err_d;
            idsel_q      <= idsel_d;
            fbdsel_q     <= fbdsel_d;
            odsel_q      <= odsel_d;
            pll_reset_q  <= pll_reset_d;
            locked_q     <= locked_d;
            busy_q       <= busy_d;
            cfg_ready_q  <= cfg_ready_d;
        end
    end

    assign cfg_ready  = cfg_ready_q;
    assign pll_reset  = pll_reset_q;
    assign pll_idsel  = idsel_q;
    assign pll_fbdsel = fbdsel_q;
    assign pll_odsel  = odsel_q;
    assign locked     = locked_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign retry_cnt  = retry_q;

endmodule
